mult_sched: RTL and testbench

Round-robin scheduler and sequencer that shares one repeated-addition multiplier datapath (`mult_datapath`) among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and swaps them so the smaller operand is the iteration count. It drives the datapath's load/state/done controls, captures the `2*XLEN` product, and returns it with the requester's index on a single valid/ready response channel. It sits between the client ports and the datapath.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_sched_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 37 +++
 rtl/mult_sched.sv | 127 ++++++++++++
 tb/tb_mult_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier scheduler and its datapath.
package mult_pkg;

  localparam logic [1:0] READY   = 2'd0;
  localparam logic [1:0] OPERATE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    RESP
  } sched_state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Client request/response channels plus datapath control/status for mult_sched.
interface mult_sched_if
  import mult_pkg::*;
#(
  parameter int unsigned XLEN = 16,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = idw(NREQ);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][XLEN-1:0] req_a;
  logic [NREQ-1:0][XLEN-1:0] req_b;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [2*XLEN-1:0]         rsp_product;
  logic                      busy;

  logic                      dp_ld_input;
  logic [1:0]                dp_state;
  logic                      dp_ready;
  logic                      dp_done;
  logic [XLEN-1:0]           dp_a;
  logic [XLEN-1:0]           dp_b;
  logic                      dp_eqz;
  logic [2*XLEN-1:0]         dp_product;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, dp_eqz, dp_product,
    output req_ready, rsp_valid, rsp_id, rsp_product, busy,
           dp_ld_input, dp_state, dp_ready, dp_done, dp_a, dp_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, dp_eqz, dp_product,
    input  req_ready, rsp_valid, rsp_id, rsp_product, busy,
           dp_ld_input, dp_state, dp_ready, dp_done, dp_a, dp_b
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr, wrapping.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  int unsigned    w_idx;
  logic [IDW-1:0] w_idx_n;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any     = 1'b0;
    w_idx   = 0;
    w_idx_n = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = 32'(ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_idx_n = IDW'(w_idx);
      if (en && !any && req[w_idx_n]) begin
        any          = 1'b1;
        gnt[w_idx_n] = 1'b1;
        gnt_id       = w_idx_n;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Shares one repeated-addition multiplier datapath among NREQ requesters,
// sequencing load/operate/done and returning each product with its owner's index.
module mult_sched
  import mult_pkg::*;
#(
  parameter int unsigned XLEN = 16,
  parameter int unsigned NREQ = 4
) (
  input logic        clk,
  input logic        resetn,
  mult_sched_if.slave bus
);

  localparam int unsigned IDW = idw(NREQ);

  sched_state_t      r_state;
  sched_state_t      w_next;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [XLEN-1:0]   r_op_a;
  logic [XLEN-1:0]   r_op_b;
  logic [2*XLEN-1:0] r_prod;
  logic              r_rsp_valid;

  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_any;
  logic              w_arb_en;
  logic [XLEN-1:0]   w_sel_a;
  logic [XLEN-1:0]   w_sel_b;

  assign w_arb_en = (r_state == IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (r_ptr),
    .en     (w_arb_en),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  assign w_sel_a = bus.req_a[w_gnt_id];
  assign w_sel_b = bus.req_b[w_gnt_id];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    bus.req_ready   = '0;
    bus.dp_ld_input = 1'b0;
    bus.dp_state    = READY;
    bus.dp_ready    = 1'b0;
    bus.dp_done     = 1'b0;
    case (r_state)
      IDLE: begin
        bus.dp_ready  = 1'b1;
        bus.req_ready = w_gnt;
        if (w_any) w_next = LOAD;
      end
      LOAD: begin
        bus.dp_ld_input = 1'b1;
        w_next          = RUN;
      end
      RUN: begin
        bus.dp_state = OPERATE;
        if (bus.dp_eqz) w_next = CAPTURE;
      end
      CAPTURE: begin
        bus.dp_state = DONE;
        bus.dp_done  = 1'b1;
        w_next       = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Larger operand becomes the addend so the iteration count is the smaller one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_prod      <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id  <= w_gnt_id;
            r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            if (w_sel_b > w_sel_a) begin
              r_op_a <= w_sel_b;
              r_op_b <= w_sel_a;
            end else begin
              r_op_a <= w_sel_a;
              r_op_b <= w_sel_b;
            end
          end
        end
        CAPTURE: begin
          r_prod      <= bus.dp_product;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_id;
  assign bus.rsp_product = r_prod;
  assign bus.busy        = (r_state != IDLE);
  assign bus.dp_a        = r_op_a;
  assign bus.dp_b        = r_op_b;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: stub repeated-addition datapath, table vectors, random
// transactions against a*b / min+4 expectations, and multi-cycle corner sequences.
module tb_mult_sched;
  import mult_pkg::*;

  localparam int unsigned XLEN = 16;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = idw(NREQ);

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  mult_sched_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

  mult_sched #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: count loads with b, adds a per nonzero count, wraps on exit.
  logic [XLEN-1:0]   dp_cnt;
  logic [2*XLEN-1:0] dp_acc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dp_cnt <= '0;
      dp_acc <= '0;
    end else if (bus.dp_ld_input) begin
      dp_cnt <= bus.dp_b;
      dp_acc <= '0;
    end else if (bus.dp_state == OPERATE) begin
      if (dp_cnt != '0) dp_acc <= dp_acc + {{XLEN{1'b0}}, bus.dp_a};
      dp_cnt <= dp_cnt - 1'b1;
    end
  end
  assign bus.dp_eqz     = (dp_cnt == '0);
  assign bus.dp_product = (bus.dp_state == DONE) ? dp_acc : 32'hDEADBEEF;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic check_reset(input string tag);
    check({tag, ".req_ready"},   64'(bus.req_ready),   0);
    check({tag, ".rsp_valid"},   64'(bus.rsp_valid),   0);
    check({tag, ".rsp_id"},      64'(bus.rsp_id),      0);
    check({tag, ".rsp_product"}, 64'(bus.rsp_product), 0);
    check({tag, ".busy"},        64'(bus.busy),        0);
    check({tag, ".dp_ld_input"}, 64'(bus.dp_ld_input), 0);
    check({tag, ".dp_state"},    64'(bus.dp_state),    64'(READY));
    check({tag, ".dp_ready"},    64'(bus.dp_ready),    1);
    check({tag, ".dp_done"},     64'(bus.dp_done),     0);
  endtask

  task automatic wait_grant(output int g, output int k);
    g = -1;
    k = 0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (|bus.req_ready) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        k = cyc;
        check("grant_onehot", 64'($countones(bus.req_ready)), 1);
        check("grant_valid", 64'(bus.req_valid[g]), 1);
        return;
      end
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL grant_timeout: got no req_ready expected a grant within 40 cycles");
  endtask

  task automatic finish_txn(input int id, input logic [31:0] prod, input int lat,
                            input int mn, input int mx, input int k, input int hold,
                            input logic [NREQ-1:0] clr);
    int run = 0;
    bit seen = 0, bad_rdy = 0, bad_hold = 0, ld = 0;
    logic [XLEN-1:0] la = '0, lb = '0;
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~clr;
    for (int t = 0; t < lat + 40; t++) begin
      #1;
      if (bus.dp_ld_input) begin ld = 1; la = bus.dp_a; lb = bus.dp_b; end
      if (bus.dp_state == OPERATE) run++;
      if (bus.rsp_valid) begin seen = 1; break; end
      if (|bus.req_ready) bad_rdy = 1;
      @(negedge clk);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one for id %0d", id);
    end else begin
      check("latency",      64'(cyc - k), 64'(lat));
      check("rsp_id",       64'(bus.rsp_id), 64'(id));
      check("rsp_product",  64'(bus.rsp_product), 64'(prod));
      check("run_cycles",   64'(run), 64'(lat - 3));
      check("load_seen",    64'(ld), 1);
      check("dp_a_larger",  64'(la), 64'(mx));
      check("dp_b_smaller", 64'(lb), 64'(mn));
      check("no_req_ready_busy", 64'(bad_rdy), 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        if (!bus.rsp_valid || bus.rsp_id !== IDW'(id) || bus.rsp_product !== prod || |bus.req_ready)
          bad_hold = 1;
      end
      if (hold > 0) check("backpressure_stable", 64'(bad_hold), 0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      check("rsp_cleared", 64'(bus.rsp_valid), 0);
      check("idle_after",  64'(bus.busy), 0);
    end
  endtask

  task automatic run_one(input int id, input int a, input int b,
                         input logic [31:0] prod, input int lat, input bit early);
    int g, k, mn, mx;
    mn = (a < b) ? a : b;
    mx = (a < b) ? b : a;
    bus.rsp_ready     = early;
    bus.req_a[id]     = XLEN'(a);
    bus.req_b[id]     = XLEN'(b);
    bus.req_valid[id] = 1'b1;
    wait_grant(g, k);
    check("grant_id", 64'(g), 64'(id));
    finish_txn(id, prod, lat, mn, mx, k, 0, NREQ'(1) << id);
  endtask

  typedef struct {
    int          id;
    int          a;
    int          b;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1);
  end

  initial begin
    int g, k, hs, ptr, mn, mx, bad, a, b, id;
    logic [31:0] p;
    tbl[0] = '{0, 7,     5,     32'd35,        9};
    tbl[1] = '{1, 2,     1000,  32'd2000,      6};
    tbl[2] = '{2, 123,   0,     32'd0,         4};
    tbl[3] = '{3, 0,     9,     32'd0,         4};
    tbl[4] = '{0, 300,   300,   32'd90000,     304};
    tbl[5] = '{1, 65535, 1,     32'd65535,     5};
    tbl[6] = '{2, 65535, 65535, 32'hFFFE0001,  65539};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #1;
    check_reset("por");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_reset("idle");

    for (int i = 0; i < 7; i++)
      run_one(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].lat, bit'(i % 2));

    for (int r = 0; r < 8; r++) begin
      id = int'($urandom_range(0, NREQ - 1));
      a  = int'($urandom_range(0, 65535));
      b  = int'($urandom_range(0, 200));
      if ($urandom_range(0, 1) == 1) begin mn = a; a = b; b = mn; end
      p  = 32'(longint'(a) * longint'(b));
      mn = (a < b) ? a : b;
      run_one(id, a, b, p, mn + 4, bit'($urandom_range(0, 1)));
    end

    // Round-robin with all requesters held valid from a fresh pointer.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i] = XLEN'(10 + 3 * i);
      bus.req_b[i] = XLEN'(2 + i);
    end
    bus.req_valid = '1;
    ptr = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, k);
      check("rr_order", 64'(g), 64'(ptr));
      mn = 2 + ptr;
      mx = 10 + 3 * ptr;
      finish_txn(ptr, 32'(mn * mx), mn + 4, mn, mx, k, 0, (n == 4) ? '1 : '0);
      ptr = (ptr + 1) % NREQ;
    end

    // Simultaneous req1/req2, then backpressure on req1 with req2 still pending.
    bus.req_a[1] = 16'd20;  bus.req_b[1] = 16'd3;
    bus.req_a[2] = 16'd9;   bus.req_b[2] = 16'd11;
    bus.req_valid = 4'b0110;
    wait_grant(g, k);
    check("simul_grant", 64'(g), 64'(ptr));
    finish_txn(1, 32'd60, 7, 3, 20, k, 10, 4'b0010);
    hs = cyc;
    wait_grant(g, k);
    check("bp_next_id", 64'(g), 2);
    check("bp_next_cycle", 64'(k), 64'(hs));
    finish_txn(2, 32'd99, 13, 9, 11, k, 0, 4'b0100);

    // Reset during RUN: nothing must come back afterwards.
    bus.req_a[3] = 16'd50;
    bus.req_b[3] = 16'd40;
    bus.req_valid[3] = 1'b1;
    wait_grant(g, k);
    check("mid_grant", 64'(g), 3);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (8) @(negedge clk);
    #1;
    check("mid_in_run", 64'(bus.dp_state), 64'(OPERATE));
    resetn = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid || bus.busy) bad = 1;
    end
    check("no_replay", 64'(bad), 0);
    run_one(3, 50, 40, 32'd2000, 44, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
